// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard hazard unit beside ID: per-register forwarding countdown and busy-until-writeback tracking.
// Define SB_STALL_STATS_EN to add free-running stall statistics counters.
module scoreboard_hazard_unit #(
  parameter int NUM_REGS  = 32,
  parameter int REG_W     = 5,
  parameter int LAT_W     = 3,
  parameter int ECALL_REG = 17
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [REG_W-1:0]    rs1,
  input  logic [REG_W-1:0]    rs2,
  input  logic                use_rs1,
  input  logic                use_rs2,
  input  logic [REG_W-1:0]    rd,
  input  logic                reg_write,
  input  logic [LAT_W-1:0]    lat,
  input  logic                is_ecall,
  input  logic                id_valid,
  input  logic                flush,
  input  logic                freeze,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_rd,
  output logic                stall,
  output logic                stall_raw,
  output logic                stall_waw,
  output logic                stall_ecall,
  output logic [NUM_REGS-1:0] busy
`ifdef SB_STALL_STATS_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         raw_cycles,
  output logic [31:0]         waw_cycles,
  output logic [31:0]         ecall_cycles
`endif
);

  logic [NUM_REGS-1:0][LAT_W-1:0] cnt_q;
  logic [NUM_REGS-1:0][LAT_W-1:0] cnt_d;
  logic [NUM_REGS-1:0]            busy_q;
  logic [NUM_REGS-1:0]            busy_d;
  logic [LAT_W-1:0]               cnt_rs1;
  logic [LAT_W-1:0]               cnt_rs2;
  logic [LAT_W-1:0]               cnt_rd;
  logic                           issue;

  assign cnt_rs1 = cnt_q[rs1];
  assign cnt_rs2 = cnt_q[rs2];
  assign cnt_rd  = cnt_q[rd];

  assign stall_raw   = id_valid & ((use_rs1 & (rs1 != '0) & (cnt_rs1 != '0)) |
                                   (use_rs2 & (rs2 != '0) & (cnt_rs2 != '0)));
  assign stall_waw   = id_valid & reg_write & (rd != '0) & busy_q[rd] & (cnt_rd > lat);
  assign stall_ecall = id_valid & is_ecall & busy_q[ECALL_REG];
  assign stall       = stall_raw | stall_waw | stall_ecall;

  assign issue = id_valid & ~stall & ~flush & ~freeze & reg_write & (rd != '0);
  assign busy  = busy_q;

  // Entry 0 is x0: never tracked, so its next state is pinned to zero.
  assign cnt_d[0]  = '0;
  assign busy_d[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_entry
      logic hit_issue;
      logic hit_wb;
      assign hit_issue  = issue & (rd == REG_W'(gi));
      assign hit_wb     = wb_valid & (wb_rd == REG_W'(gi));
      assign cnt_d[gi]  = hit_issue ? lat :
                          (cnt_q[gi] != '0) ? cnt_q[gi] - LAT_W'(1) : '0;
      // A new producer wins over a writeback retiring the previous one.
      assign busy_d[gi] = hit_issue | (busy_q[gi] & ~hit_wb);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      busy_q <= '0;
    end else if (!freeze) begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

`ifdef SB_STALL_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] raw_cycles_q;
  logic [31:0] waw_cycles_q;
  logic [31:0] ecall_cycles_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_q <= '0;
      raw_cycles_q   <= '0;
      waw_cycles_q   <= '0;
      ecall_cycles_q <= '0;
    end else if (!freeze) begin
      if (stall)       stall_cycles_q <= stall_cycles_q + 32'd1;
      if (stall_raw)   raw_cycles_q   <= raw_cycles_q + 32'd1;
      if (stall_waw)   waw_cycles_q   <= waw_cycles_q + 32'd1;
      if (stall_ecall) ecall_cycles_q <= ecall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign raw_cycles   = raw_cycles_q;
  assign waw_cycles   = waw_cycles_q;
  assign ecall_cycles = ecall_cycles_q;
`endif

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Self-checking bench for scoreboard_hazard_unit: directed hazard scenarios then randomized traffic
// against a timestamp-based model (honours SB_STALL_STATS_EN when defined).
module tb_scoreboard_hazard_unit;
  localparam int NUM_REGS  = 32;
  localparam int REG_W     = 5;
  localparam int LAT_W     = 3;
  localparam int ECALL_REG = 17;

  logic clk = 1'b0;
  logic reset_n;
  logic [REG_W-1:0] rs1, rs2, rd, wb_rd;
  logic use_rs1, use_rs2, reg_write, is_ecall, id_valid, flush, freeze, wb_valid;
  logic [LAT_W-1:0] lat;
  logic stall, stall_raw, stall_waw, stall_ecall;
  logic [NUM_REGS-1:0] busy;
`ifdef SB_STALL_STATS_EN
  logic [31:0] stall_cycles, raw_cycles, waw_cycles, ecall_cycles;
`endif

  scoreboard_hazard_unit #(
    .NUM_REGS(NUM_REGS), .REG_W(REG_W), .LAT_W(LAT_W), .ECALL_REG(ECALL_REG)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .rd(rd), .reg_write(reg_write), .lat(lat), .is_ecall(is_ecall),
    .id_valid(id_valid), .flush(flush), .freeze(freeze),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall(stall), .stall_raw(stall_raw), .stall_waw(stall_waw),
    .stall_ecall(stall_ecall), .busy(busy)
`ifdef SB_STALL_STATS_EN
    ,
    .stall_cycles(stall_cycles), .raw_cycles(raw_cycles),
    .waw_cycles(waw_cycles), .ecall_cycles(ecall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a register is forwardable once the advancing-cycle count reaches ready_tick.
  longint tick;
  longint ready_tick [NUM_REGS];
  bit     busy_m     [NUM_REGS];

  logic obs_stall, obs_raw, obs_waw, obs_ecall;
  logic [NUM_REGS-1:0] obs_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint remaining(input int r);
    if (r == 0) return 0;
    return (ready_tick[r] > tick) ? ready_tick[r] - tick : 0;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NUM_REGS; r++) begin
      ready_tick[r] = tick;
      busy_m[r]     = 1'b0;
    end
  endtask

  // One clock: check outputs at negedge against the model, then advance the model at posedge.
  task automatic cycle();
    bit e_raw, e_waw, e_ecall, e_stall, e_issue;
    logic [NUM_REGS-1:0] e_busy;
    @(negedge clk);
    if (!reset_n) model_clear();
    e_raw   = id_valid && ((use_rs1 && remaining(int'(rs1)) != 0) ||
                           (use_rs2 && remaining(int'(rs2)) != 0));
    e_waw   = id_valid && reg_write && rd != 0 && busy_m[rd] &&
              remaining(int'(rd)) > longint'(lat);
    e_ecall = id_valid && is_ecall && busy_m[ECALL_REG];
    e_stall = e_raw || e_waw || e_ecall;
    for (int r = 0; r < NUM_REGS; r++) e_busy[r] = busy_m[r];
    obs_stall = stall; obs_raw = stall_raw; obs_waw = stall_waw;
    obs_ecall = stall_ecall; obs_busy = busy;
    chk("stall", {31'd0, stall}, {31'd0, e_stall});
    chk("stall_raw", {31'd0, stall_raw}, {31'd0, e_raw});
    chk("stall_waw", {31'd0, stall_waw}, {31'd0, e_waw});
    chk("stall_ecall", {31'd0, stall_ecall}, {31'd0, e_ecall});
    chk("busy", busy, e_busy);
    e_issue = id_valid && !e_stall && !flush && !freeze && reg_write && rd != 0;
    @(posedge clk);
    if (reset_n && !freeze) begin
      tick++;
      if (wb_valid && wb_rd != 0) busy_m[wb_rd] = 1'b0;
      if (e_issue) begin
        ready_tick[rd] = tick + longint'(lat);
        busy_m[rd]     = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle();
    id_valid = 0; use_rs1 = 0; use_rs2 = 0; reg_write = 0; is_ecall = 0;
    flush = 0; freeze = 0; wb_valid = 0;
    rs1 = '0; rs2 = '0; rd = '0; wb_rd = '0; lat = '0;
  endtask

  task automatic issue_op(input int r, input int l);
    idle();
    id_valid = 1; reg_write = 1; rd = REG_W'(r); lat = LAT_W'(l);
    cycle();
  endtask

  function automatic logic [REG_W-1:0] pick_reg();
    int v;
    v = $urandom_range(0, 5);
    return (v == 5) ? REG_W'(ECALL_REG) : REG_W'(v);
  endfunction

  int n;

  initial begin
    tick = 0;
    model_clear();
    idle();
    reset_n = 0;

    // Reset with a would-be consumer present.
    id_valid = 1; use_rs1 = 1; rs1 = 5'd5;
    cycle(); cycle();
    chk("rst_stall", {31'd0, obs_stall}, 32'd0);
    chk("rst_busy", obs_busy, 32'd0);
    reset_n = 1;

    // Load-use: exactly one bubble.
    issue_op(5, 1);
    idle(); id_valid = 1; use_rs1 = 1; rs1 = 5'd5;
    cycle();
    chk("lu_stall", {31'd0, obs_stall}, 32'd1);
    chk("lu_raw", {31'd0, obs_raw}, 32'd1);
    cycle();
    chk("lu_clear", {31'd0, obs_stall}, 32'd0);

    // Multi-cycle producer, lat=3 -> 3 stall cycles.
    issue_op(8, 3);
    idle(); id_valid = 1; use_rs2 = 1; rs2 = 5'd8;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (obs_stall) n++; else break;
    end
    chk("mc_stall_cycles", n, 3);

    // Same with freeze for 2 cycles mid-wait -> 5 stall cycles.
    issue_op(8, 3);
    idle(); id_valid = 1; use_rs2 = 1; rs2 = 5'd8;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      freeze = (i == 1 || i == 2);
      cycle();
      if (obs_stall) n++; else break;
    end
    freeze = 0;
    chk("mc_freeze_cycles", n, 5);

    // WAW: lat=0 rewrite waits out the countdown.
    issue_op(9, 3);
    idle(); id_valid = 1; reg_write = 1; rd = 5'd9; lat = '0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (obs_waw) n++; else break;
    end
    chk("waw_cycles", n, 3);
    // WAW boundary: remaining 2 is not greater than new lat 2.
    issue_op(9, 3);
    idle(); cycle();
    issue_op(9, 2);
    chk("waw_equal", {31'd0, obs_waw}, 32'd0);

    // Ecall waits for ECALL_REG writeback.
    issue_op(17, 0);
    idle(); id_valid = 1; is_ecall = 1;
    cycle();
    chk("ecall_stall", {31'd0, obs_ecall}, 32'd1);
    cycle();
    wb_valid = 1; wb_rd = 5'd17;
    cycle();
    chk("ecall_at_wb", {31'd0, obs_ecall}, 32'd1);
    wb_valid = 0;
    cycle();
    chk("ecall_after_wb", {31'd0, obs_stall}, 32'd0);

    // Same-cycle writeback and issue to x12: issue wins.
    issue_op(12, 0);
    idle(); id_valid = 1; reg_write = 1; rd = 5'd12; wb_valid = 1; wb_rd = 5'd12;
    cycle();
    idle(); cycle();
    chk("collide_busy12", {31'd0, obs_busy[12]}, 32'd1);

    // x0 writes are never tracked.
    issue_op(0, 5);
    idle(); id_valid = 1; use_rs1 = 1; rs1 = '0;
    cycle();
    chk("x0_stall", {31'd0, obs_stall}, 32'd0);
    chk("x0_busy", {31'd0, obs_busy[0]}, 32'd0);

    // Flushed writer leaves no trace.
    idle(); id_valid = 1; reg_write = 1; rd = 5'd4; lat = 3'd3; flush = 1;
    cycle();
    idle(); id_valid = 1; use_rs1 = 1; rs1 = 5'd4;
    cycle();
    chk("flush_busy4", {31'd0, obs_busy[4]}, 32'd0);
    chk("flush_stall", {31'd0, obs_stall}, 32'd0);

    // Fresh reset, then four load-use sequences for the statistics counters.
    idle(); reset_n = 0;
    cycle();
    reset_n = 1;
    for (int k = 0; k < 4; k++) begin
      issue_op(20 + k, 1);
      idle(); id_valid = 1; use_rs1 = 1; rs1 = REG_W'(20 + k);
      cycle(); cycle();
    end
    idle(); cycle();
`ifdef SB_STALL_STATS_EN
    chk("stat_stall", stall_cycles, 32'd4);
    chk("stat_raw", raw_cycles, 32'd4);
    chk("stat_waw", waw_cycles, 32'd0);
    chk("stat_ecall", ecall_cycles, 32'd0);
`endif

    // Randomized traffic on a small register pool, with one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      reset_n   = (i != 200);
      id_valid  = ($urandom_range(0, 9) != 0);
      use_rs1   = $urandom_range(0, 1);
      use_rs2   = $urandom_range(0, 1);
      rs1       = pick_reg();
      rs2       = pick_reg();
      rd        = pick_reg();
      reg_write = $urandom_range(0, 1);
      lat       = LAT_W'($urandom_range(0, 7));
      is_ecall  = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      freeze    = ($urandom_range(0, 9) == 0);
      wb_valid  = $urandom_range(0, 1);
      wb_rd     = pick_reg();
      cycle();
    end
    reset_n = 1;
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scoreboard_hazard_unit.md
Name: scoreboard_hazard_unit

Overview:
Parametrised scoreboard-based hazard unit for the pipelined CPU, placed alongside ID.
- Tracks per-register cycles-until-forwardable and busy-until-writeback state for in-flight producers.
- Producers may be ALU, load or multi-cycle.
- Stalls ID on RAW, WAW and ecall hazards, and reports which one fired.
- Supports pipeline freeze and ID flush.

Parameters:
NUM_REGS, 32, architectural register count; x0 never tracked.
REG_W, 5, register address width (clog2 NUM_REGS).
LAT_W, 3, width of latency field and per-register countdown counters.
ECALL_REG, 17, register an ecall in ID reads; must be fully written back before ecall proceeds.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
rs1  in  REG_W  ID source 1
rs2  in  REG_W  ID source 2
use_rs1  in  1  ID instruction reads rs1
use_rs2  in  1  ID instruction reads rs2
rd  in  REG_W  ID destination
reg_write  in  1  ID instruction writes rd
lat  in  LAT_W  cycles after issue before rd is forwardable to ID (ALU 0, load 1, mul/div up to 2^LAT_W-1)
is_ecall  in  1  ID instruction is ecall
id_valid  in  1  ID holds a real instruction (not bubble)
flush  in  1  ID instruction is being squashed this cycle
freeze  in  1  whole pipeline held (memory stall); state frozen
wb_valid  in  1  writeback occurring
wb_rd  in  REG_W  writeback destination
stall  out  1  hold PC/IF-ID, inject bubble into ID/EX
stall_raw  out  1  stall cause: source pending
stall_waw  out  1  stall cause: destination pending longer than new lat
stall_ecall  out  1  stall cause: ECALL_REG busy
busy  out  NUM_REGS  per-register busy-until-writeback vector

Behaviour:
- State: cnt[r] (LAT_W bits) and busy[r] for r = 1..NUM_REGS-1; index 0 hardwired 0.
- Reset (async, reset_n low): all cnt = 0, all busy = 0. Hence stall and all cause outputs are 0 and busy = 0 during and right after reset. Reset mid-operation discards all pending state immediately.
- stall_raw = id_valid & ((use_rs1 & rs1!=0 & cnt[rs1]!=0) | (use_rs2 & rs2!=0 & cnt[rs2]!=0)).
- stall_waw = id_valid & reg_write & rd!=0 & busy[rd] & (cnt[rd] > lat).
- stall_ecall = id_valid & is_ecall & busy[ECALL_REG].
- stall = OR of causes. All combinational from current state and inputs; zero-latency.
- issue = id_valid & ~stall & ~flush & ~freeze & reg_write & rd!=0.
- Per-cycle update (posedge, skipped entirely when freeze=1):
  - every nonzero cnt decrements by 1, saturating at 0;
  - on issue: cnt[rd] <= lat (overrides decrement), busy[rd] <= 1;
  - on wb_valid & wb_rd!=0: busy[wb_rd] <= 0, unless issue targets the same register in that cycle, in which case issue wins and busy stays 1.
- The load-use case yields exactly one bubble: a load issued with lat=1 makes a dependent instruction stall 1 cycle. lat=0 producers never stall consumers.
- freeze holds cnt and busy. wb_valid is ignored while freeze=1. stall outputs still evaluate.
- flush suppresses issue only; existing entries untouched.
- Issue with lat=0 still sets busy (ecall sensitivity) but leaves cnt at 0.

Optional Feature:
Macro SB_STALL_STATS_EN.
- Defined: adds outputs stall_cycles[31:0], raw_cycles[31:0], waw_cycles[31:0], ecall_cycles[31:0]. Each increments by 1 on every non-freeze cycle where the corresponding signal is 1, wraps at 2^32, and resets to 0 on reset_n.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset: hold reset_n=0 with id_valid=1, use_rs1=1, rs1=5 -> stall=0, busy=0. Release, issue rd=5 lat=1 -> next cycle rs1=5 gives stall=1, stall_raw=1; following cycle stall=0.
- Multi-cycle: issue rd=8 lat=3; consumer rs2=8 use_rs2=1 -> stall for exactly 3 cycles, then 0. Assert freeze for 2 cycles mid-wait -> total stall spans 5 cycles.
- WAW: issue rd=9 lat=3; next cycle issue rd=9 lat=0 -> stall_waw=1 until cnt[9]=0. rd=9 lat=2 next cycle -> no stall (cnt 2 not > 2).
- Ecall: issue rd=17 lat=0; is_ecall=1 -> stall_ecall=1 until wb_valid with wb_rd=17, then stall=0 the cycle after.
- Same-cycle collision: wb_rd=12 and issue rd=12 together -> busy[12] stays 1. x0 writes (rd=0) never set busy and never stall; flush=1 with rd=4 leaves busy[4]=0.
- With SB_STALL_STATS_EN: run the load-use sequence 4 times -> stall_cycles=4, raw_cycles=4, waw_cycles=0, ecall_cycles=0.
